// File: rtl/hangman_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// hangman_game_ctrl_if
// Byte channel from the game sequencer to the radio transmitter.
//   tx_valid : byte offered (driven by the master)
//   tx_data  : ASCII byte offered, stable while tx_valid & !tx_ready
//   tx_ready : transmitter can accept a byte (driven by the slave)
// A byte is transferred on every clock edge where tx_valid & tx_ready.
// -----------------------------------------------------------------------------
interface hangman_game_ctrl_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/hangman_game_ctrl.sv
// -----------------------------------------------------------------------------
// hangman_game_ctrl
// Central sequencer for wireless hangman: collects the secret word from the
// keypad, sends it to the radio, then runs the guessing round (duplicate
// rejection, reveal, mistake counting, win/lose) and drives LEDs and the
// revealed-word text for the LCD.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   role_switch   : 0 = host/setup phase, 1 = player/guess phase
//   key_valid     : one-cycle pulse, key_char holds a committed letter
//   key_char      : ASCII letter from the keypad decoder
//   key_submit    : one-cycle pulse, submit-word key
//   tx            : valid/ready byte channel to the transmitter (master side)
//   msg_sent      : one-cycle pulse after the last word byte is accepted
//   revealed      : WORD_LEN chars, char 0 in [7:0], hidden chars are '_'
//   mistakes      : wrong-guess count
//   red/green     : LOSE / WIN
//   blue          : SETUP, SEND or WAIT_ROLE
//   error         : one-cycle pulse on a rejected input
// -----------------------------------------------------------------------------
module hangman_game_ctrl #(
    parameter int WORD_LEN     = 5,
    parameter int MAX_MISTAKES = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    role_switch,
    input  logic                    key_valid,
    input  logic [7:0]              key_char,
    input  logic                    key_submit,
    hangman_game_ctrl_if.master     tx,
    output logic                    msg_sent,
    output logic [8*WORD_LEN-1:0]   revealed,
    output logic [2:0]              mistakes,
    output logic                    red,
    output logic                    green,
    output logic                    blue,
    output logic                    error
);

    // Counter width must be able to hold WORD_LEN itself (the "word full" value).
    localparam int            CW       = $clog2(WORD_LEN + 1);
    localparam logic [CW-1:0] FULL_IDX = CW'(WORD_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(WORD_LEN - 1);
    localparam logic [2:0]    MAX_M    = 3'(MAX_MISTAKES);
    localparam logic [7:0]    BLANK    = 8'h5F;

    typedef enum logic [2:0] {
        ST_SETUP     = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_ROLE = 3'd2,
        ST_GUESS     = 3'd3,
        ST_CHECK     = 3'd4,
        ST_WIN       = 3'd5,
        ST_LOSE      = 3'd6
    } state_t;

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= 8'h41) && (c <= 8'h5A);
    endfunction

    function automatic logic [4:0] letter_idx(input logic [7:0] c);
        return 5'(c - 8'h41);
    endfunction

    state_t                     state_q, state_d;
    logic [CW-1:0]              idx_q, idx_d;
    logic [CW-1:0]              tx_idx_q, tx_idx_d;
    logic [WORD_LEN-1:0][7:0]   word_q, word_d;
    logic [WORD_LEN-1:0]        mask_q, mask_d;
    logic [25:0]                used_q, used_d;
    logic [2:0]                 mist_cnt_q, mist_cnt_d;
    logic [7:0]                 guess_q, guess_d;
    logic [WORD_LEN-1:0]        hit_s;

    logic                       tx_valid_q, tx_valid_d;
    logic [7:0]                 tx_data_q, tx_data_d;
    logic                       msg_sent_q, msg_sent_d;
    logic                       error_q, error_d;
    logic                       red_q, red_d;
    logic                       green_q, green_d;
    logic                       blue_q, blue_d;
    logic [2:0]                 mistakes_q, mistakes_d;
    logic [WORD_LEN-1:0][7:0]   revealed_q, revealed_d;

    // Game state machine: next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_idx_d   = tx_idx_q;
        word_d     = word_q;
        mask_d     = mask_q;
        used_d     = used_q;
        mist_cnt_d = mist_cnt_q;
        guess_d    = guess_q;
        msg_sent_d = 1'b0;
        error_d    = 1'b0;
        hit_s      = '0;

        case (state_q)
            ST_SETUP: begin
                // Submit has priority; a key arriving in the same cycle is dropped.
                if (key_submit) begin
                    if (idx_q == FULL_IDX) begin
                        state_d  = ST_SEND;
                        tx_idx_d = '0;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (key_valid) begin
                    if (!is_letter(key_char) || (idx_q == FULL_IDX)) begin
                        error_d = 1'b1;
                    end else begin
                        for (int i = 0; i < WORD_LEN; i++) begin
                            word_d[i] = (idx_q == CW'(i)) ? key_char : word_q[i];
                        end
                        idx_d = idx_q + CW'(1);
                    end
                end else begin
                    error_d = 1'b0;
                end
            end

            ST_SEND: begin
                if (tx_valid_q && tx.tx_ready) begin
                    if (tx_idx_q == LAST_IDX) begin
                        state_d    = ST_WAIT_ROLE;
                        msg_sent_d = 1'b1;
                        tx_idx_d   = '0;
                    end else begin
                        tx_idx_d = tx_idx_q + CW'(1);
                    end
                end else begin
                    tx_idx_d = tx_idx_q;
                end
            end

            ST_WAIT_ROLE: begin
                if (role_switch) begin
                    state_d    = ST_GUESS;
                    mask_d     = '0;
                    used_d     = '0;
                    mist_cnt_d = 3'd0;
                end else begin
                    state_d = ST_WAIT_ROLE;
                end
            end

            ST_GUESS: begin
                if (!role_switch) begin
                    state_d    = ST_SETUP;
                    idx_d      = '0;
                    word_d     = '0;
                    mask_d     = '0;
                    used_d     = '0;
                    mist_cnt_d = 3'd0;
                end else if (key_valid) begin
                    // Short-circuit keeps the used[] lookup in range for non-letters.
                    if (!is_letter(key_char) || used_q[letter_idx(key_char)]) begin
                        error_d = 1'b1;
                    end else begin
                        guess_d                        = key_char;
                        used_d[letter_idx(key_char)]   = 1'b1;
                        state_d                        = ST_CHECK;
                    end
                end else begin
                    state_d = ST_GUESS;
                end
            end

            ST_CHECK: begin
                for (int i = 0; i < WORD_LEN; i++) begin
                    hit_s[i] = (word_q[i] == guess_q);
                end
                mask_d = mask_q | hit_s;
                if (hit_s == '0) begin
                    mist_cnt_d = mist_cnt_q + 3'd1;
                end else begin
                    mist_cnt_d = mist_cnt_q;
                end
                // Win is tested first so a completing hit on the last attempt wins.
                if (&mask_d) begin
                    state_d = ST_WIN;
                end else if (mist_cnt_d == MAX_M) begin
                    state_d = ST_LOSE;
                end else begin
                    state_d = ST_GUESS;
                end
            end

            ST_WIN, ST_LOSE: begin
                if (!role_switch) begin
                    state_d    = ST_SETUP;
                    idx_d      = '0;
                    word_d     = '0;
                    mask_d     = '0;
                    used_d     = '0;
                    mist_cnt_d = 3'd0;
                end else begin
                    state_d = state_q;
                end
            end

            default: begin
                state_d = ST_SETUP;
            end
        endcase
    end

    // Transmit channel: computed from next-state values so tx_valid/tx_data
    // change on the same edge as the handshake bookkeeping.
    always_comb begin
        tx_valid_d = (state_d == ST_SEND);
        tx_data_d  = 8'h00;
        for (int i = 0; i < WORD_LEN; i++) begin
            tx_data_d = tx_data_d | ({8{tx_valid_d && (tx_idx_d == CW'(i))}} & word_d[i]);
        end
    end

    // Display and LED outputs: registered from the current state, so they
    // follow a state update by one edge.
    always_comb begin
        red_d      = (state_q == ST_LOSE);
        green_d    = (state_q == ST_WIN);
        blue_d     = (state_q == ST_SETUP) || (state_q == ST_SEND) ||
                     (state_q == ST_WAIT_ROLE);
        mistakes_d = mist_cnt_q;
        for (int i = 0; i < WORD_LEN; i++) begin
            case (state_q)
                ST_GUESS, ST_CHECK: revealed_d[i] = mask_q[i] ? word_q[i] : BLANK;
                ST_WIN, ST_LOSE:    revealed_d[i] = word_q[i];
                default:            revealed_d[i] = BLANK;
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_SETUP;
            idx_q      <= '0;
            tx_idx_q   <= '0;
            word_q     <= '0;
            mask_q     <= '0;
            used_q     <= '0;
            mist_cnt_q <= 3'd0;
            guess_q    <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            msg_sent_q <= 1'b0;
            error_q    <= 1'b0;
            red_q      <= 1'b0;
            green_q    <= 1'b0;
            blue_q     <= 1'b1;
            mistakes_q <= 3'd0;
            revealed_q <= {WORD_LEN{BLANK}};
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_idx_q   <= tx_idx_d;
            word_q     <= word_d;
            mask_q     <= mask_d;
            used_q     <= used_d;
            mist_cnt_q <= mist_cnt_d;
            guess_q    <= guess_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            msg_sent_q <= msg_sent_d;
            error_q    <= error_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            mistakes_q <= mistakes_d;
            revealed_q <= revealed_d;
        end
    end

    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = tx_data_q;
    assign msg_sent    = msg_sent_q;
    assign error       = error_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign mistakes    = mistakes_q;
    assign revealed    = revealed_q;

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hangman_game_ctrl
// Directed bench for hangman_game_ctrl (WORD_LEN=5, MAX_MISTAKES=6).
// Inputs change just after the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_hangman_game_ctrl;

    logic        clk;
    logic        rst;
    logic        role_switch;
    logic        key_valid;
    logic [7:0]  key_char;
    logic        key_submit;
    logic        msg_sent;
    logic [39:0] revealed;
    logic [2:0]  mistakes;
    logic        red, green, blue, error;

    int checks = 0;
    int errors = 0;

    localparam logic [39:0] ALL_BLANK = 40'h5F5F5F5F5F;
    localparam logic [39:0] APPLE     = 40'h454C505041;

    logic [7:0] exp_word [5] = '{8'h41, 8'h50, 8'h50, 8'h4C, 8'h45};

    hangman_game_ctrl_if tx_if ();

    hangman_game_ctrl #(.WORD_LEN(5), .MAX_MISTAKES(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .role_switch (role_switch),
        .key_valid   (key_valid),
        .key_char    (key_char),
        .key_submit  (key_submit),
        .tx          (tx_if),
        .msg_sent    (msg_sent),
        .revealed    (revealed),
        .mistakes    (mistakes),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] c);
        key_valid = 1'b1;
        key_char  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_char  = 8'h00;
    endtask

    task automatic submit();
        key_submit = 1'b1;
        @(negedge clk);
        key_submit = 1'b0;
    endtask

    task automatic enter_apple();
        for (int i = 0; i < 5; i++) press(exp_word[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got=%0h exp=0", tx_if.tx_valid); end
        checks++; if (tx_if.tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got=%0h exp=00", tx_if.tx_data); end
        checks++; if (msg_sent !== 1'b0) begin errors++; $display("FAIL rst_msg_sent got=%0h exp=0", msg_sent); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got=%0h exp=0", error); end
        checks++; if ({red, green, blue} !== 3'b001) begin errors++; $display("FAIL rst_leds got=%b exp=001", {red, green, blue}); end
        checks++; if (mistakes !== 3'd0) begin errors++; $display("FAIL rst_mistakes got=%0d exp=0", mistakes); end
        checks++; if (revealed !== ALL_BLANK) begin errors++; $display("FAIL rst_revealed got=%h exp=%h", revealed, ALL_BLANK); end
        rst = 1'b0;
    endtask

    task automatic test_setup_errors();
        press(8'h41); press(8'h50); press(8'h50);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL letter_no_err got=%0h exp=0", error); end
        submit();
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL early_submit_err got=%0h exp=1", error); end
        step(1);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_one_cycle got=%0h exp=0", error); end
        checks++; if (tx_if.tx_valid !== 1'b0 || blue !== 1'b1) begin errors++; $display("FAIL early_submit_stay got=%0h/%0h exp=0/1", tx_if.tx_valid, blue); end
        press(8'h4C); press(8'h45);
        press(8'h5A);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL sixth_letter_err got=%0h exp=1", error); end
        press(8'h31);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL setup_invalid_err got=%0h exp=1", error); end
        step(1);
    endtask

    task automatic test_send_stall();
        int  k;
        int  cyc;
        logic rdy;
        tx_if.tx_ready = 1'b0;
        key_valid = 1'b1; key_char = 8'h51; key_submit = 1'b1;
        @(negedge clk);
        key_valid = 1'b0; key_char = 8'h00; key_submit = 1'b0;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL submit_wins_no_err got=%0h exp=0", error); end
        k = 0; cyc = 0; rdy = 1'b0;
        while (k < 5 && cyc < 40) begin
            checks++;
            if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== exp_word[k]) begin
                errors++; $display("FAIL stall_byte%0d got=%0h/%h exp=1/%h", k, tx_if.tx_valid, tx_if.tx_data, exp_word[k]);
            end
            rdy = ~rdy;
            tx_if.tx_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) k++;
        end
        tx_if.tx_ready = 1'b0;
        checks++; if (cyc >= 40) begin errors++; $display("FAIL stall_timeout got=%0d exp=<40", cyc); end
        checks++; if (msg_sent !== 1'b1 || tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL stall_msg_sent got=%0h/%0h exp=1/0", msg_sent, tx_if.tx_valid); end
        step(1);
        checks++; if (msg_sent !== 1'b0) begin errors++; $display("FAIL msg_sent_pulse got=%0h exp=0", msg_sent); end
    endtask

    task automatic test_win();
        logic [7:0]  g  [5] = '{8'h50, 8'h48, 8'h41, 8'h45, 8'h4C};
        logic [39:0] rv [5] = '{40'h5F5F50505F, 40'h5F5F50505F, 40'h5F5F505041, 40'h455F505041, APPLE};
        logic [2:0]  mk [5] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1};
        logic [2:0]  prev;
        logic        exp_g;
        role_switch = 1'b1;
        step(2);
        checks++; if (blue !== 1'b0 || revealed !== ALL_BLANK) begin errors++; $display("FAIL guess_entry got=%0h/%h exp=0/%h", blue, revealed, ALL_BLANK); end
        prev = 3'd0;
        for (int i = 0; i < 5; i++) begin
            exp_g = (i == 4);
            press(g[i]);
            checks++; if (error !== 1'b0) begin errors++; $display("FAIL win_guess%0d_err got=%0h exp=0", i, error); end
            step(1);
            checks++; if (mistakes !== prev) begin errors++; $display("FAIL win_latency%0d got=%0d exp=%0d", i, mistakes, prev); end
            step(1);
            checks++; if (revealed !== rv[i]) begin errors++; $display("FAIL win_revealed%0d got=%h exp=%h", i, revealed, rv[i]); end
            checks++; if (mistakes !== mk[i]) begin errors++; $display("FAIL win_mistakes%0d got=%0d exp=%0d", i, mistakes, mk[i]); end
            checks++; if (green !== exp_g || red !== 1'b0) begin errors++; $display("FAIL win_leds%0d got=%0h/%0h exp=%0h/0", i, green, red, exp_g); end
            prev = mk[i];
        end
        press(8'h58);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL win_key_ignored got=%0h exp=0", error); end
        step(1);
        checks++; if (green !== 1'b1 || revealed !== APPLE) begin errors++; $display("FAIL win_hold got=%0h/%h exp=1/%h", green, revealed, APPLE); end
        role_switch = 1'b0;
        step(2);
        checks++; if ({red, green, blue} !== 3'b001) begin errors++; $display("FAIL win_to_setup got=%b exp=001", {red, green, blue}); end
        checks++; if (revealed !== ALL_BLANK || mistakes !== 3'd0) begin errors++; $display("FAIL win_cleared got=%h/%0d exp=%h/0", revealed, mistakes, ALL_BLANK); end
    endtask

    task automatic test_back_to_back();
        enter_apple();
        tx_if.tx_ready = 1'b1;
        submit();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== exp_word[k]) begin
                errors++; $display("FAIL b2b_byte%0d got=%0h/%h exp=1/%h", k, tx_if.tx_valid, tx_if.tx_data, exp_word[k]);
            end
            step(1);
        end
        checks++; if (msg_sent !== 1'b1 || tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_msg_sent got=%0h/%0h exp=1/0", msg_sent, tx_if.tx_valid); end
        tx_if.tx_ready = 1'b0;
        role_switch = 1'b1;
        step(2);
    endtask

    task automatic test_dup_invalid();
        press(8'h50);
        step(2);
        checks++; if (revealed !== 40'h5F5F50505F || mistakes !== 3'd0) begin errors++; $display("FAIL dup_first got=%h/%0d exp=5f5f50505f/0", revealed, mistakes); end
        press(8'h50);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL dup_err got=%0h exp=1", error); end
        step(2);
        checks++; if (mistakes !== 3'd0) begin errors++; $display("FAIL dup_mistakes got=%0d exp=0", mistakes); end
        press(8'h61);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL lower_err got=%0h exp=1", error); end
        step(1);
        checks++; if (error !== 1'b0 || mistakes !== 3'd0) begin errors++; $display("FAIL lower_after got=%0h/%0d exp=0/0", error, mistakes); end
    endtask

    task automatic test_lose();
        logic [7:0] m [6] = '{8'h42, 8'h43, 8'h44, 8'h46, 8'h47, 8'h48};
        logic [2:0] em_old;
        logic [2:0] em_new;
        logic       exp_r;
        for (int i = 0; i < 6; i++) begin
            em_old = 3'(i);
            em_new = 3'(i + 1);
            exp_r  = (i == 5);
            press(m[i]);
            step(1);
            checks++; if (mistakes !== em_old || red !== 1'b0) begin errors++; $display("FAIL lose_hold%0d got=%0d/%0h exp=%0d/0", i, mistakes, red, em_old); end
            step(1);
            checks++; if (mistakes !== em_new || red !== exp_r) begin errors++; $display("FAIL lose_miss%0d got=%0d/%0h exp=%0d/%0h", i, mistakes, red, em_new, exp_r); end
        end
        checks++; if (revealed !== APPLE || green !== 1'b0) begin errors++; $display("FAIL lose_revealed got=%h/%0h exp=%h/0", revealed, green, APPLE); end
        press(8'h4A);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL lose_key_ignored got=%0h exp=0", error); end
        step(2);
        checks++; if (mistakes !== 3'd6 || red !== 1'b1) begin errors++; $display("FAIL lose_hold_end got=%0d/%0h exp=6/1", mistakes, red); end
        role_switch = 1'b0;
        step(2);
        checks++; if ({red, green, blue} !== 3'b001 || mistakes !== 3'd0) begin errors++; $display("FAIL lose_to_setup got=%b/%0d exp=001/0", {red, green, blue}, mistakes); end
    endtask

    task automatic test_reset_mid_send();
        enter_apple();
        tx_if.tx_ready = 1'b0;
        submit();
        step(1);
        checks++; if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 8'h41) begin errors++; $display("FAIL mid_send_hold got=%0h/%h exp=1/41", tx_if.tx_valid, tx_if.tx_data); end
        #2 rst = 1'b1;
        #1;
        checks++; if (tx_if.tx_valid !== 1'b0 || tx_if.tx_data !== 8'h00) begin errors++; $display("FAIL mid_send_rst_tx got=%0h/%h exp=0/00", tx_if.tx_valid, tx_if.tx_data); end
        checks++; if (blue !== 1'b1 || mistakes !== 3'd0) begin errors++; $display("FAIL mid_send_rst_out got=%0h/%0d exp=1/0", blue, mistakes); end
        @(negedge clk);
        rst = 1'b0;
        submit();
        checks++; if (error !== 1'b1 || tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL mid_send_rst_idx got=%0h/%0h exp=1/0", error, tx_if.tx_valid); end
    endtask

    initial begin
        rst            = 1'b1;
        role_switch    = 1'b0;
        key_valid      = 1'b0;
        key_char       = 8'h00;
        key_submit     = 1'b0;
        tx_if.tx_ready = 1'b0;
        test_reset();
        test_setup_errors();
        test_send_stall();
        test_win();
        test_back_to_back();
        test_dup_invalid();
        test_lose();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hangman_game_ctrl.md
Name: hangman_game_ctrl

Overview:
Central game sequencer for wireless hangman. Collects the host's secret word from the keypad decoder and ships it to the radio transmitter over a valid/ready handshake. It then runs the player's guessing round: duplicate-guess rejection, letter reveal, mistake counting and win/lose detection. It drives the status LEDs and the revealed-word text consumed by the LCD row formatter.

Parameters:
WORD_LEN, 5, letters in secret word (1..8)
MAX_MISTAKES, 6, wrong guesses allowed before loss (1..7)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
role_switch  in  1  0 = host/setup phase, 1 = player/guess phase
key_valid  in  1  one-cycle pulse, committed letter from keypad decoder
key_char  in  8  ASCII letter, valid with key_valid
key_submit  in  1  one-cycle pulse, submit-word key
tx_ready  in  1  transmitter can accept a byte
tx_valid  out  1  byte offered to transmitter
tx_data  out  8  ASCII byte offered
msg_sent  out  1  one-cycle pulse after the last word byte is accepted
revealed  out  8*WORD_LEN  guess-phase display; char 0 in bits [7:0]; unrevealed = 0x5F '_'
mistakes  out  3  wrong-guess count
red  out  1  LOSE
green  out  1  WIN
blue  out  1  SETUP/SEND/WAIT_ROLE
error  out  1  one-cycle pulse on a rejected input

Behaviour:
- Reset (async, any state): state=SETUP, letter index=0, word cleared, mask=0, used-letter vector (26b)=0, mistakes=0.
- Reset output values: tx_valid=0, tx_data=0, msg_sent=0, error=0, red=0, green=0, blue=1, revealed = all 0x5F.
- Valid letter: key_char in 0x41..0x5A. Any other value with key_valid gives an error pulse and no state change.
- SETUP:
  - Valid key_valid with idx<WORD_LEN: word[idx]=key_char, idx++.
  - Valid key_valid with idx==WORD_LEN: error pulse, key ignored.
  - key_submit with idx==WORD_LEN: go to SEND, tx_idx=0.
  - key_submit with idx<WORD_LEN: error pulse, stay in SETUP.
  - key_submit and key_valid in the same cycle: submit wins, key is dropped.
- SEND:
  - tx_valid=1, tx_data=word[tx_idx]. tx_data is held stable while tx_valid & !tx_ready.
  - On tx_valid&tx_ready: tx_idx++.
  - After the last byte is accepted: tx_valid=0 next cycle, msg_sent pulses for that cycle, go to WAIT_ROLE.
  - Keys are ignored; no error pulses.
- WAIT_ROLE: on role_switch==1, go to GUESS and clear mask, used, mistakes.
- GUESS:
  - Valid key_valid with used[letter] already set: error pulse, stay; mistakes unchanged.
  - Otherwise: latch guess, set used[letter], go to CHECK.
  - role_switch==0: abort to SETUP and clear everything.
- CHECK (exactly one cycle):
  - hit[i] = (word[i]==guess); mask |= hit.
  - If hit==0: mistakes++.
  - Next state uses the updated values: mask all-ones -> WIN; else mistakes==MAX_MISTAKES -> LOSE; else GUESS.
  - A reveal that completes the word on the final allowed attempt is a WIN (no mistake is added on a hit).
- Latency: key_valid sampled at edge N -> CHECK during cycle N..N+1 -> revealed, mistakes and state updated at edge N+2.
- WIN (green=1) / LOSE (red=1):
  - Keys are ignored.
  - role_switch==0 -> SETUP with word, idx, mask, used, mistakes cleared.
  - revealed shows the full word in both WIN and LOSE.
- revealed outside GUESS/CHECK/WIN/LOSE: all 0x5F.
- blue=1 only in SETUP, SEND, WAIT_ROLE.
- LED outputs and tx_valid are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset mid-SEND with tx_ready=0 and tx_valid=1 -> tx_valid=0 immediately, state SETUP, blue=1, mistakes=0.
- Word entry: key A,P,P,L,E then key_submit, tx_ready=1 -> 5 bytes 0x41,0x50,0x50,0x4C,0x45 on consecutive cycles, then msg_sent pulse. With tx_ready toggling every other cycle -> the same bytes, each held while stalled.
- Early submit after 3 letters -> error pulse, stays SETUP. A 6th letter -> error pulse, word unchanged.
- Win path: role_switch=1, guesses P,H,A,E,L ->
  - after P: revealed "_PP__";
  - H gives mistakes=1;
  - after L: green=1, revealed "APPLE".
  - role_switch=0 -> SETUP, blue=1.
- Duplicate/invalid guess: P twice -> second gives error pulse, mistakes unchanged. key_char=0x61 -> error pulse.
- Lose path: six distinct misses (B,C,D,F,G,H) -> mistakes=6 at edge N+2 of the 6th guess, red=1, further keys ignored.
